// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// then publishes diff, borrow_out, overflow and zero with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               br_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               a_msb_q;
  logic               b_msb_q;

  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   diff_q;
  logic               borrow_out_q;
  logic               overflow_q;
  logic               zero_q;

  logic               bit_d;
  logic               br_d;
  logic [WIDTH-1:0]   res_d;
  logic               last_bit;

  // One full-subtractor cell acting on the current LSBs of the operand registers.
  always_comb begin
    bit_d    = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d    = {bit_d, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      overflow_q   <= 1'b0;
      zero_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= borrow_in;
            res_q   <= '0;
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end

        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // The final bit is the sign bit of the result, hence bit_d in the overflow term.
          if (last_bit) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            diff_q       <= res_d;
            borrow_out_q <= br_d;
            overflow_q   <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
            zero_q       <= (res_d == '0);
            state_q      <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): vector table plus hand-written corner
// sequences, with expected results queued at start and retired on done.
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
    logic         z;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         zero;

  int checks = 0;
  int errors = 0;

  res_t sb_q[$];
  res_t prev;
  vec_t tbl[16];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi);
    logic [W:0] full;
    res_t r;
    full   = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    r.diff = full[W-1:0];
    r.bo   = full[W];
    r.ov   = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
    r.z    = (full[W-1:0] == '0);
    return r;
  endfunction

  task automatic chk_hold(input string tag);
    chk({tag, " diff hold"}, 32'(diff), 32'(prev.diff));
    chk({tag, " borrow hold"}, 32'(borrow_out), 32'(prev.bo));
    chk({tag, " ovf hold"}, 32'(overflow), 32'(prev.ov));
    chk({tag, " zero hold"}, 32'(zero), 32'(prev.z));
  endtask

  // Called at a negedge; start is sampled by the following posedge (edge 0).
  // Returns at the negedge of the done cycle so a back-to-back call starts on done.
  task automatic run_op(input vec_t v, input bit restart);
    res_t e;
    res_t got;
    string tag;
    e.diff = v.diff; e.bo = v.bo; e.ov = v.ov; e.z = v.z;
    tag = $sformatf("op a=%h b=%h bi=%0d", v.a, v.b, v.bi);
    a = v.a; b = v.b; borrow_in = v.bi; start = 1'b1;
    sb_q.push_back(e);
    for (int k = 0; k <= W; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
      end
      if (restart && k == 1) begin
        a = '1; b = '0; borrow_in = 1'b0; start = 1'b1;
      end
      if (restart && k == 2) start = 1'b0;
      chk({tag, " busy"}, 32'(busy), 32'(k < W));
      chk({tag, " done"}, 32'(done), 32'(k == W));
      if (k < W) chk_hold(tag);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk({tag, " scoreboard empty"}, 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          got.diff = diff; got.bo = borrow_out; got.ov = overflow; got.z = zero;
          chk({tag, " result"}, 32'(got), 32'(e));
          prev = e;
        end
      end
    end
    $display("op a=%h b=%h bi=%0d -> diff=%h bo=%0d ov=%0d z=%0d", v.a, v.b, v.bi,
             diff, borrow_out, overflow, zero);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " done"}, 32'(done), 32'(0));
    chk({tag, " diff"}, 32'(diff), 32'(0));
    chk({tag, " borrow"}, 32'(borrow_out), 32'(0));
    chk({tag, " ovf"}, 32'(overflow), 32'(0));
    chk({tag, " zero"}, 32'(zero), 32'(1));
  endtask

  initial begin
    res_t m;
    // Expected values for fixed rows are worked by hand; random rows use the model.
    tbl[0] = '{a:4'b0101, b:4'b0011, bi:1'b0, diff:4'b0010, bo:1'b0, ov:1'b0, z:1'b0};
    tbl[1] = '{a:4'b0011, b:4'b0101, bi:1'b0, diff:4'b1110, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[2] = '{a:4'b0111, b:4'b1000, bi:1'b0, diff:4'b1111, bo:1'b1, ov:1'b1, z:1'b0};
    tbl[3] = '{a:4'b1001, b:4'b1000, bi:1'b1, diff:4'b0000, bo:1'b0, ov:1'b0, z:1'b1};
    tbl[4] = '{a:4'b0000, b:4'b0000, bi:1'b1, diff:4'b1111, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[5] = '{a:4'b1000, b:4'b0001, bi:1'b0, diff:4'b0111, bo:1'b0, ov:1'b1, z:1'b0};
    tbl[6] = '{a:4'b1111, b:4'b1111, bi:1'b1, diff:4'b1111, bo:1'b1, ov:1'b0, z:1'b0};
    tbl[7] = '{a:4'b0000, b:4'b0000, bi:1'b0, diff:4'b0000, bo:1'b0, ov:1'b0, z:1'b1};
    for (int i = 8; i < 16; i++) begin
      tbl[i].a  = W'($urandom);
      tbl[i].b  = W'($urandom);
      tbl[i].bi = 1'($urandom);
      m = model(tbl[i].a, tbl[i].b, tbl[i].bi);
      tbl[i].diff = m.diff; tbl[i].bo = m.bo; tbl[i].ov = m.ov; tbl[i].z = m.z;
    end

    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    prev = '{diff:'0, bo:1'b0, ov:1'b0, z:1'b1};
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Table: alternate idle gaps and back-to-back starts on the done cycle.
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i], 1'b0);
      if (i % 3 == 2) @(negedge clk);
    end

    // A second start two cycles into an operation must be ignored.
    @(negedge clk);
    run_op(tbl[0], 1'b1);
    // Start on the done cycle: busy must rise on the next cycle.
    run_op(tbl[2], 1'b0);

    // Reset mid-SHIFT discards the operation.
    @(negedge clk);
    a = 4'b0101; b = 4'b0011; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-abort busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("abort");
    prev = '{diff:'0, bo:1'b0, ov:1'b0, z:1'b1};
    rst = 1'b0;
    // Start on the first edge after reset release; no stale done may appear.
    run_op(tbl[1], 1'b0);
    @(negedge clk);
    chk("final done low", 32'(done), 32'(0));
    chk("scoreboard drained", 32'(sb_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
